// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported integer register file with a pending-write scoreboard.
// RPORTS registered read ports, WPORTS write ports, and a hard-wired zero register.
// Optional feature: define REGFILE_BYPASS_EN for write-first forwarding of read
// data and ready. When it is undefined, reads see the pre-edge state (read-first).
module regfile_mp #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int RPORTS   = 2,
  parameter int WPORTS   = 2,
  parameter int ZERO_REG = DEPTH - 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [RPORTS*$clog2(DEPTH)-1:0] rd_addr,
  output logic [RPORTS*WIDTH-1:0]     rd_data,
  output logic [RPORTS-1:0]           rd_ready,
  input  logic [WPORTS-1:0]           wr_en,
  input  logic [WPORTS*$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WPORTS*WIDTH-1:0]     wr_data,
  input  logic                        iss_en,
  input  logic [$clog2(DEPTH)-1:0]    iss_addr,
  output logic [$clog2(DEPTH+1)-1:0]  pending_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

  // Architectural state
  logic [WIDTH-1:0]          mem [DEPTH];
  logic [DEPTH-1:0]          pend;

  // Per-register write decode and the next pending vector
  logic [DEPTH-1:0]          wr_hit;
  logic [WIDTH-1:0]          wr_val [DEPTH];
  logic [DEPTH-1:0]          pend_nxt;

  // Read stage
  logic [RPORTS*WIDTH-1:0]   rd_data_p0;
  logic [RPORTS-1:0]         rd_ready_p0;
  logic [RPORTS*WIDTH-1:0]   rd_data_p1;
  logic [RPORTS-1:0]         rd_ready_p1;
  logic [CW-1:0]             pending_cnt_p1;

  // Population count of a pending vector
  function automatic logic [CW-1:0] popcnt(input logic [DEPTH-1:0] v);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      s = s + CW'(v[i]);
    end
    return s;
  endfunction

  // Decode writes per register; later ports override earlier ones on a collision
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wr_hit[i] = 1'b0;
      wr_val[i] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      for (int w = 0; w < WPORTS; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] == AW'(i)) && (AW'(i) != ZERO_A)) begin
          wr_hit[i] = 1'b1;
          wr_val[i] = wr_data[w*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Next pending vector: a write clears, a same-cycle issue re-sets (new producer wins)
  always_comb begin
    pend_nxt = pend & ~wr_hit;
    if (iss_en && (iss_addr != ZERO_A)) begin
      pend_nxt[iss_addr] = 1'b1;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Read-port muxing with write-first forwarding from the same-edge writes and issue
  always_comb begin
    rd_data_p0  = '0;
    rd_ready_p0 = '1;
    for (int p = 0; p < RPORTS; p++) begin
      rd_data_p0[p*WIDTH +: WIDTH] = mem[rd_addr[p*AW +: AW]];
      for (int w = 0; w < WPORTS; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW])) begin
          rd_data_p0[p*WIDTH +: WIDTH] = wr_data[w*WIDTH +: WIDTH];
        end
      end
      rd_ready_p0[p] = ~pend_nxt[rd_addr[p*AW +: AW]];
      if (rd_addr[p*AW +: AW] == ZERO_A) begin
        rd_data_p0[p*WIDTH +: WIDTH] = '0;
        rd_ready_p0[p]               = 1'b1;
      end
    end
  end
`else
  // Read-port muxing from the pre-edge array and pending state
  always_comb begin
    rd_data_p0  = '0;
    rd_ready_p0 = '1;
    for (int p = 0; p < RPORTS; p++) begin
      rd_data_p0[p*WIDTH +: WIDTH] = mem[rd_addr[p*AW +: AW]];
      rd_ready_p0[p]               = ~pend[rd_addr[p*AW +: AW]];
      if (rd_addr[p*AW +: AW] == ZERO_A) begin
        rd_data_p0[p*WIDTH +: WIDTH] = '0;
        rd_ready_p0[p]               = 1'b1;
      end
    end
  end
`endif

  // Storage and scoreboard update; reset clears everything and overrides writes/issues
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      pend <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_hit[i]) begin
          mem[i] <= wr_val[i];
        end
      end
      pend <= pend_nxt;
    end
  end

  // ---- stage p0 -> p1: registered read ports and pending count ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_data_p1     <= '0;
      rd_ready_p1    <= '1;
      pending_cnt_p1 <= '0;
    end else begin
      rd_data_p1     <= rd_data_p0;
      rd_ready_p1    <= rd_ready_p0;
      pending_cnt_p1 <= popcnt(pend_nxt);
    end
  end

  assign rd_data     = rd_data_p1;
  assign rd_ready    = rd_ready_p1;
  assign pending_cnt = pending_cnt_p1;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed plus randomized bench for regfile_mp with a
// behavioural register/pending model. Honors REGFILE_BYPASS_EN like the design.
module tb_regfile_mp;

  localparam int WIDTH  = 64;
  localparam int DEPTH  = 32;
  localparam int RPORTS = 2;
  localparam int WPORTS = 2;
  localparam int ZREG   = DEPTH - 1;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = $clog2(DEPTH + 1);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                     clk;
  logic                     reset_n;
  logic [RPORTS*AW-1:0]     rd_addr;
  logic [RPORTS*WIDTH-1:0]  rd_data;
  logic [RPORTS-1:0]        rd_ready;
  logic [WPORTS-1:0]        wr_en;
  logic [WPORTS*AW-1:0]     wr_addr;
  logic [WPORTS*WIDTH-1:0]  wr_data;
  logic                     iss_en;
  logic [AW-1:0]            iss_addr;
  logic [CW-1:0]            pending_cnt;

  regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RPORTS(RPORTS), .WPORTS(WPORTS), .ZERO_REG(ZREG)) dut (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .pending_cnt(pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [WIDTH-1:0] m_reg  [DEPTH];
  bit               m_pend [DEPTH];
  logic [WIDTH-1:0] e_data [RPORTS];
  logic             e_rdy  [RPORTS];
  int               e_cnt;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_read();
    for (int p = 0; p < RPORTS; p++) begin
      int a;
      a = int'(rd_addr[p*AW +: AW]);
      if (a == ZREG) begin
        e_data[p] = '0;
        e_rdy[p]  = 1'b1;
      end else begin
        e_data[p] = m_reg[a];
        e_rdy[p]  = !m_pend[a];
      end
    end
  endtask

  // One clock: advance the model with the current inputs, then compare all outputs
  task automatic cycle(input string tag);
    @(posedge clk);
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_reg[i]  = '0;
        m_pend[i] = 1'b0;
      end
      for (int p = 0; p < RPORTS; p++) begin
        e_data[p] = '0;
        e_rdy[p]  = 1'b1;
      end
    end else begin
      if (!BYPASS) model_read();
      for (int w = 0; w < WPORTS; w++) begin
        int a;
        a = int'(wr_addr[w*AW +: AW]);
        if (wr_en[w] && a != ZREG) begin
          m_reg[a]  = wr_data[w*WIDTH +: WIDTH];
          m_pend[a] = 1'b0;
        end
      end
      if (iss_en && int'(iss_addr) != ZREG) m_pend[int'(iss_addr)] = 1'b1;
      if (BYPASS) model_read();
    end
    e_cnt = 0;
    for (int i = 0; i < DEPTH; i++) e_cnt += int'(m_pend[i]);
    #1;
    for (int p = 0; p < RPORTS; p++) begin
      chk($sformatf("%s.data%0d", tag, p), rd_data[p*WIDTH +: WIDTH], e_data[p]);
      chk($sformatf("%s.rdy%0d", tag, p), WIDTH'(rd_ready[p]), WIDTH'(e_rdy[p]));
    end
    chk($sformatf("%s.cnt", tag), WIDTH'(pending_cnt), WIDTH'(e_cnt));
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; iss_en = 1'b0; iss_addr = '0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr[0*AW +: AW] = AW'(a0);
    rd_addr[1*AW +: AW] = AW'(a1);
  endtask

  task automatic set_wr(input int w, input int a, input logic [WIDTH-1:0] d);
    wr_en[w] = 1'b1;
    wr_addr[w*AW +: AW] = AW'(a);
    wr_data[w*WIDTH +: WIDTH] = d;
  endtask

  initial begin
    reset_n = 1'b0; rd_addr = '0; idle();
    cycle("init_reset");
    reset_n = 1'b1;

    // Reset overrides a same-cycle write
    for (int k = 0; k < 3; k++) begin
      idle(); set_wr(0, 3, 64'h55); set_rd(3, 3);
      cycle("pre_reset_wr");
    end
    reset_n = 1'b0; idle(); set_wr(0, 3, 64'h55); iss_en = 1'b1; iss_addr = 5'd3;
    cycle("reset_with_wr");
    chk("reset.data0", rd_data[63:0], 64'h0);
    chk("reset.ready", WIDTH'(rd_ready), WIDTH'(2'b11));
    chk("reset.cnt", WIDTH'(pending_cnt), 64'd0);
    reset_n = 1'b1; idle(); set_rd(3, 3);
    cycle("read_r3_after_reset");
    chk("r3_after_reset", rd_data[63:0], 64'h0);

    // Basic write then read on both ports
    idle(); set_wr(0, 5, 64'hDEAD_BEEF_0000_0001);
    cycle("wr_r5");
    idle(); set_rd(5, 5);
    cycle("rd_r5");
    chk("r5.p0", rd_data[63:0], 64'hDEAD_BEEF_0000_0001);
    chk("r5.p1", rd_data[127:64], 64'hDEAD_BEEF_0000_0001);
    chk("r5.ready", WIDTH'(rd_ready), WIDTH'(2'b11));

    // Zero register ignores writes and issues
    idle(); set_wr(1, ZREG, '1); iss_en = 1'b1; iss_addr = AW'(ZREG); set_rd(ZREG, ZREG);
    cycle("zero_wr");
    idle();
    cycle("zero_rd");
    chk("zero.data", rd_data[63:0], 64'h0);
    chk("zero.ready", WIDTH'(rd_ready), WIDTH'(2'b11));
    chk("zero.cnt", WIDTH'(pending_cnt), 64'd0);

    // Same-address write conflict: highest port wins
    idle(); set_wr(0, 7, 64'h11); set_wr(1, 7, 64'h22);
    cycle("conflict_wr");
    idle(); set_rd(7, 0);
    cycle("conflict_rd");
    chk("conflict.r7", rd_data[63:0], 64'h22);

    // Scoreboard: issue, clear by write, then issue+write together
    idle(); iss_en = 1'b1; iss_addr = 5'd4; set_rd(4, 4);
    cycle("iss_r4");
    chk("iss_r4.cnt", WIDTH'(pending_cnt), 64'd1);
    idle();
    cycle("iss_r4_rd");
    chk("iss_r4.ready", WIDTH'(rd_ready[0]), 64'd0);
    idle(); set_wr(0, 4, 64'h9);
    cycle("wr_r4");
    chk("wr_r4.cnt", WIDTH'(pending_cnt), 64'd0);
    idle();
    cycle("wr_r4_rd");
    chk("wr_r4.ready", WIDTH'(rd_ready[0]), 64'd1);
    chk("wr_r4.data", rd_data[63:0], 64'h9);
    idle(); iss_en = 1'b1; iss_addr = 5'd4; set_wr(1, 4, 64'h77);
    cycle("iss_wr_r4");
    chk("iss_wr_r4.cnt", WIDTH'(pending_cnt), 64'd1);
    idle(); iss_en = 1'b1; iss_addr = 5'd4;
    cycle("reissue_r4");
    chk("reissue_r4.cnt", WIDTH'(pending_cnt), 64'd1);
    idle();
    cycle("iss_wr_r4_rd");
    chk("iss_wr_r4.data", rd_data[63:0], 64'h77);
    chk("iss_wr_r4.ready", WIDTH'(rd_ready[0]), 64'd0);

    // Same-edge write and read of r2
    idle(); set_wr(0, 2, 64'hA); set_rd(2, 2);
    cycle("byp_wr");
    chk("byp.same_edge", rd_data[63:0], BYPASS ? 64'hA : 64'h0);
    idle();
    cycle("byp_next");
    chk("byp.next_edge", rd_data[63:0], 64'hA);

    // Randomized traffic over a narrow address window to force collisions
    for (int n = 0; n < 400; n++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      for (int w = 0; w < WPORTS; w++) begin
        wr_en[w] = $urandom_range(0, 1);
        wr_addr[w*AW +: AW] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH-1)
                                                               : $urandom_range(24, DEPTH-1));
        wr_data[w*WIDTH +: WIDTH] = {$urandom, $urandom};
      end
      iss_en   = ($urandom_range(0, 2) != 0);
      iss_addr = AW'($urandom_range(0, DEPTH-1));
      for (int p = 0; p < RPORTS; p++) begin
        rd_addr[p*AW +: AW] = AW'(($urandom_range(0, 1) == 0) ? $urandom_range(0, DEPTH-1)
                                                               : $urandom_range(24, DEPTH-1));
      end
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
